// File: rtl/lsu_mem_if.sv
// Data-memory request/acknowledge bus between the load/store sequencer and memory.
interface lsu_mem_if #(
  parameter int n = 32
);
  logic         mem_req;
  logic         mem_we;
  logic [n-1:0] mem_addr;
  logic [3:0]   mem_be;
  logic [n-1:0] mem_wdata;
  logic         mem_ack;
  logic [n-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store sequencer: decodes a memory instruction, runs one
// req/ack transfer and returns an extended load result with fault reporting.
//
// state | meaning
// IDLE  | no transfer, waiting for start
// REQ   | mem_req held until mem_ack or timeout
// DONE  | one-cycle completion (done=1), may accept the next start
module lsu_ctrl #(
  parameter int n       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         MemRw,
  input  logic [2:0]   LoadStoreMode,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  output logic         stall,
  output logic         done,
  output logic         fault,
  output logic [n-1:0] rdata,
  lsu_mem_if.master    mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_TC = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state;
  logic [2:0]    mode_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt;

  logic          illegal;
  logic          misaligned;
  logic [3:0]    be_dec;
  logic [n-1:0]  wdata_dec;
  logic [n-1:0]  shifted;
  logic [n-1:0]  load_val;

  always_comb begin
    if (MemRw)
      illegal = LoadStoreMode[2] | (LoadStoreMode == 3'b011);
    else
      illegal = (LoadStoreMode == 3'b011) | (LoadStoreMode[2:1] == 2'b11);
    misaligned = ((LoadStoreMode[1:0] == 2'b01) & addr[0]) |
                 ((LoadStoreMode[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    case (LoadStoreMode[1:0])
      2'b00: begin
        be_dec    = 4'b0001 << addr[1:0];
        wdata_dec = {(n/8){wdata[7:0]}};
      end
      2'b01: begin
        be_dec    = 4'b0011 << {addr[1], 1'b0};
        wdata_dec = {(n/16){wdata[15:0]}};
      end
      default: begin
        be_dec    = 4'b1111;
        wdata_dec = wdata;
      end
    endcase
  end

  // Extraction works on the captured offset/mode since addr may change during REQ.
  always_comb begin
    shifted = mem.mem_rdata >> {off_q, 3'b000};
    case (mode_q)
      3'b000:  load_val = {{(n-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{(n-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {{(n-8){1'b0}}, shifted[7:0]};
      3'b101:  load_val = {{(n-16){1'b0}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  assign stall = (state == REQ) | (start & ((state == IDLE) | (state == DONE)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      done          <= 1'b0;
      fault         <= 1'b0;
      rdata         <= '0;
      mode_q        <= '0;
      off_q         <= '0;
      cnt           <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          if (start) begin
            mode_q <= LoadStoreMode;
            off_q  <= addr[1:0];
            if (illegal | misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state         <= REQ;
              cnt           <= '0;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= MemRw;
              mem.mem_addr  <= {addr[n-1:2], 2'b00};
              mem.mem_be    <= be_dec;
              mem.mem_wdata <= wdata_dec;
            end
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            state       <= DONE;
            done        <= 1'b1;
            fault       <= 1'b0;
            mem.mem_req <= 1'b0;
            if (!mem.mem_we)
              rdata <= load_val;
          end else if ((TIMEOUT != 0) && (cnt == CNT_TC)) begin
            state       <= DONE;
            done        <= 1'b1;
            fault       <= 1'b1;
            mem.mem_req <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: per-scenario tasks with a scoreboard of
// expected completions (fault, rdata) pushed at start and popped at done.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        MemRw;
  logic [2:0]  LoadStoreMode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        fault;
  logic [31:0] rdata;

  lsu_mem_if #(.n(32)) m ();

  lsu_ctrl #(.n(32), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .MemRw         (MemRw),
    .LoadStoreMode (LoadStoreMode),
    .addr          (addr),
    .wdata         (wdata),
    .stall         (stall),
    .done          (done),
    .fault         (fault),
    .rdata         (rdata),
    .mem           (m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int          done_cyc;
    int          first_req;
    int          nreq;
    int          req_stall;
    logic        stall0;
    logic        fault;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } obs_t;

  exp_t        sb[$];
  int          vec  = 0;
  int          miss = 0;
  logic [31:0] model_rdata = 32'h0;

  // Drives one instruction starting now (just after a rising edge) and runs
  // the memory side; ack_at = index of the REQ cycle that acks, <0 = never.
  task automatic drive_op(input logic rw, input logic [2:0] mode, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word, input int ack_at,
                          output obs_t o);
    int cyc;
    cyc = 0;
    o.done_cyc = -1; o.first_req = -1; o.nreq = 0; o.req_stall = 0;
    o.fault = 1'bx; o.we = 1'bx; o.rdata = 'x; o.addr = 'x; o.wdata = 'x; o.be = 'x;
    start = 1'b1; MemRw = rw; LoadStoreMode = mode; addr = a; wdata = wd;
    m.mem_ack = 1'b0; m.mem_rdata = word;
    #1 o.stall0 = stall;
    while (cyc < 40) begin
      @(posedge clk); #1; cyc++;
      start = 1'b0;
      if (done) begin
        o.done_cyc = cyc; o.fault = fault; o.rdata = rdata;
        m.mem_ack = 1'b0;
        break;
      end
      if (m.mem_req) begin
        if (o.first_req < 0) o.first_req = cyc;
        o.addr = m.mem_addr; o.be = m.mem_be; o.wdata = m.mem_wdata; o.we = m.mem_we;
        m.mem_ack = (o.nreq == ack_at);
        o.nreq++;
        if (stall) o.req_stall++;
      end else begin
        m.mem_ack = 1'b0;
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; MemRw = 1'b0; LoadStoreMode = 3'b000;
    addr = '0; wdata = '0; m.mem_ack = 1'b0; m.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    vec++; if ({done, fault, stall} !== 3'b000) begin miss++; $display("FAIL reset_flags got=%b exp=000", {done, fault, stall}); end
    vec++; if ({m.mem_req, m.mem_we} !== 2'b00) begin miss++; $display("FAIL reset_req_we got=%b exp=00", {m.mem_req, m.mem_we}); end
    vec++; if ({m.mem_addr, m.mem_wdata, m.mem_be} !== 68'h0) begin miss++; $display("FAIL reset_bus got=%h/%h/%b exp=0", m.mem_addr, m.mem_wdata, m.mem_be); end
    vec++; if (rdata !== 32'h0) begin miss++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_load_word;
    obs_t o; exp_t e;
    sb.push_back('{fault: 1'b0, rdata: 32'hDEADBEEF});
    drive_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, o);
    e = sb.pop_front();
    model_rdata = e.rdata;
    vec++; if (o.done_cyc !== 2) begin miss++; $display("FAIL lw_done_cycle got=%0d exp=2", o.done_cyc); end
    vec++; if (o.first_req !== 1) begin miss++; $display("FAIL lw_req_cycle got=%0d exp=1", o.first_req); end
    vec++; if (o.addr !== 32'h100 || o.be !== 4'b1111 || o.we !== 1'b0) begin miss++; $display("FAIL lw_bus got=%h/%b/%b exp=00000100/1111/0", o.addr, o.be, o.we); end
    vec++; if (o.fault !== e.fault || o.rdata !== e.rdata) begin miss++; $display("FAIL lw_result got=%b/%h exp=%b/%h", o.fault, o.rdata, e.fault, e.rdata); end
    idle(1);
  endtask

  task automatic test_load_byte;
    obs_t o; exp_t e;
    sb.push_back('{fault: 1'b0, rdata: 32'hFFFFFF80});
    drive_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, o);
    e = sb.pop_front();
    model_rdata = e.rdata;
    vec++; if (o.be !== 4'b1000 || o.addr !== 32'h100) begin miss++; $display("FAIL lb_bus got=%b/%h exp=1000/00000100", o.be, o.addr); end
    vec++; if (o.fault !== e.fault || o.rdata !== e.rdata) begin miss++; $display("FAIL lb_result got=%b/%h exp=%b/%h", o.fault, o.rdata, e.fault, e.rdata); end
    sb.push_back('{fault: 1'b0, rdata: 32'h00000080});
    drive_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, o);
    e = sb.pop_front();
    model_rdata = e.rdata;
    vec++; if (o.be !== 4'b1000) begin miss++; $display("FAIL lbu_be got=%b exp=1000", o.be); end
    vec++; if (o.fault !== e.fault || o.rdata !== e.rdata) begin miss++; $display("FAIL lbu_result got=%b/%h exp=%b/%h", o.fault, o.rdata, e.fault, e.rdata); end
    idle(1);
  endtask

  task automatic test_store_half;
    obs_t o; exp_t e;
    sb.push_back('{fault: 1'b0, rdata: model_rdata});
    drive_op(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 3, o);
    e = sb.pop_front();
    vec++; if (o.addr !== 32'h20 || o.be !== 4'b1100) begin miss++; $display("FAIL sh_addr_be got=%h/%b exp=00000020/1100", o.addr, o.be); end
    vec++; if (o.wdata !== 32'hABCDABCD || o.we !== 1'b1) begin miss++; $display("FAIL sh_wdata_we got=%h/%b exp=abcdabcd/1", o.wdata, o.we); end
    vec++; if (o.nreq !== 4 || o.req_stall !== 4 || o.stall0 !== 1'b1) begin miss++; $display("FAIL sh_stall got=req%0d/stall%0d/s0=%b exp=4/4/1", o.nreq, o.req_stall, o.stall0); end
    vec++; if (o.fault !== e.fault || o.rdata !== e.rdata) begin miss++; $display("FAIL sh_result got=%b/%h exp=%b/%h", o.fault, o.rdata, e.fault, e.rdata); end
    idle(1);
  endtask

  task automatic test_decode_fault;
    obs_t o; exp_t e;
    sb.push_back('{fault: 1'b1, rdata: model_rdata});
    drive_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h11111111, 0, o);
    e = sb.pop_front();
    vec++; if (o.done_cyc !== 1 || o.nreq !== 0 || o.stall0 !== 1'b1) begin miss++; $display("FAIL lw_misaligned got=done%0d/req%0d/s0=%b exp=1/0/1", o.done_cyc, o.nreq, o.stall0); end
    vec++; if (o.fault !== e.fault || o.rdata !== e.rdata) begin miss++; $display("FAIL lw_misaligned_result got=%b/%h exp=%b/%h", o.fault, o.rdata, e.fault, e.rdata); end
    idle(1);
    sb.push_back('{fault: 1'b1, rdata: model_rdata});
    drive_op(1'b1, 3'b110, 32'h200, 32'h12345678, 32'h0, 0, o);
    e = sb.pop_front();
    vec++; if (o.done_cyc !== 1 || o.nreq !== 0) begin miss++; $display("FAIL sw_illegal got=done%0d/req%0d exp=1/0", o.done_cyc, o.nreq); end
    vec++; if (o.fault !== e.fault || o.rdata !== e.rdata) begin miss++; $display("FAIL sw_illegal_result got=%b/%h exp=%b/%h", o.fault, o.rdata, e.fault, e.rdata); end
    idle(1);
  endtask

  task automatic test_timeout;
    obs_t o; exp_t e; int bad;
    sb.push_back('{fault: 1'b1, rdata: model_rdata});
    drive_op(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, -1, o);
    e = sb.pop_front();
    vec++; if (o.nreq !== 4 || o.done_cyc !== 5) begin miss++; $display("FAIL timeout_len got=req%0d/done%0d exp=4/5", o.nreq, o.done_cyc); end
    vec++; if (o.fault !== e.fault || o.rdata !== e.rdata) begin miss++; $display("FAIL timeout_result got=%b/%h exp=%b/%h", o.fault, o.rdata, e.fault, e.rdata); end
    bad = 0;
    m.mem_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || m.mem_req || rdata !== model_rdata) bad++;
    end
    m.mem_ack = 1'b0;
    vec++; if (bad !== 0) begin miss++; $display("FAIL timeout_late_ack got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_reset_in_req;
    int bad;
    start = 1'b1; MemRw = 1'b0; LoadStoreMode = 3'b010; addr = 32'h80;
    m.mem_ack = 1'b0; m.mem_rdata = 32'h76543210;
    @(posedge clk); #1;
    start = 1'b0;
    vec++; if (m.mem_req !== 1'b1) begin miss++; $display("FAIL rst_req_entry got=%b exp=1", m.mem_req); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    model_rdata = 32'h0;
    vec++; if ({m.mem_req, m.mem_we, done, fault, stall} !== 5'b0) begin miss++; $display("FAIL rst_in_req_flags got=%b exp=00000", {m.mem_req, m.mem_we, done, fault, stall}); end
    vec++; if ({m.mem_addr, m.mem_wdata, m.mem_be, rdata} !== 100'h0) begin miss++; $display("FAIL rst_in_req_data got=%h/%h/%b/%h exp=0", m.mem_addr, m.mem_wdata, m.mem_be, rdata); end
    rst = 1'b0;
    m.mem_ack = 1'b1;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || m.mem_req || rdata !== 32'h0) bad++;
    end
    m.mem_ack = 1'b0;
    vec++; if (bad !== 0) begin miss++; $display("FAIL rst_stale_ack got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_back_to_back;
    obs_t o; exp_t e;
    sb.push_back('{fault: 1'b0, rdata: model_rdata});
    drive_op(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 0, o);
    e = sb.pop_front();
    vec++; if (o.be !== 4'b0010 || o.wdata !== 32'hA5A5A5A5 || o.addr !== 32'h100) begin miss++; $display("FAIL sb_bus got=%b/%h/%h exp=0010/a5a5a5a5/00000100", o.be, o.wdata, o.addr); end
    vec++; if (o.done_cyc !== 2 || o.fault !== e.fault || o.rdata !== e.rdata) begin miss++; $display("FAIL sb_result got=%0d/%b/%h exp=2/%b/%h", o.done_cyc, o.fault, o.rdata, e.fault, e.rdata); end
    sb.push_back('{fault: 1'b0, rdata: 32'h12345678});
    drive_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 0, o);
    e = sb.pop_front();
    model_rdata = e.rdata;
    vec++; if (o.stall0 !== 1'b1 || o.first_req !== 1 || o.done_cyc !== 2) begin miss++; $display("FAIL b2b_timing got=s0=%b/req%0d/done%0d exp=1/1/2", o.stall0, o.first_req, o.done_cyc); end
    vec++; if (o.fault !== e.fault || o.rdata !== e.rdata || o.addr !== 32'h40) begin miss++; $display("FAIL b2b_result got=%b/%h/%h exp=%b/%h/00000040", o.fault, o.rdata, o.addr, e.fault, e.rdata); end
    idle(1);
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_load_byte;
    test_store_half;
    test_decode_fault;
    test_timeout;
    test_reset_in_req;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store sequencer between the core's decode/execute stage and data memory. Captures a memory instruction from the decoder's `MemRw`/`LoadStoreMode` outputs plus the ALU address and rs2 value, drives a req/ack handshake to memory with word-aligned address, byte enables and lane-replicated store data, and returns a sign- or zero-extended load result. It stalls the core while a transfer is outstanding and flags misaligned, illegal and timed-out accesses.

## Interface
- `n`, 32: data/address width; byte-lane logic is fixed at 4 lanes.
- `TIMEOUT`, 255: maximum REQ cycles without `mem_ack`; 0 disables the timeout.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  memory instruction present (load or store); sampled in IDLE and DONE.
- `MemRw`  in  1  1 = store, 0 = load.
- `LoadStoreMode`  in  3  funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr`  in  n  byte address from ALU.
- `wdata`  in  n  store data (rs2).
- `stall`  out  1  hold PC/pipeline (combinational).
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  valid with `done`: misaligned, illegal mode or timeout.
- `rdata`  out  n  extended load result, valid while `done`=1, held afterwards.
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  n  {addr[n-1:2], 2'b00}.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  n  lane-replicated store data.
- `mem_ack`  in  1  memory accepted or completed the request; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  n  read word.

## Operation
- States: IDLE, REQ, DONE.
- IDLE or DONE with `start`=1: decode and capture mode, `addr[1:0]`, `MemRw`. If legal and aligned, go to REQ. Otherwise go to DONE with `fault`=1 and issue no memory request.
- Illegal: loads with mode 011, 110 or 111. Stores with mode[2]=1 or mode 011.
- Misaligned: H/HU with addr[0]=1. W with addr[1:0]≠00.
- IDLE or DONE with `start`=0: go to IDLE.
- REQ: `mem_req`=1, and all `mem_*` outputs are stable from registers.
  - On `mem_ack`, go to DONE with `fault`=0. For loads, register the extracted result into `rdata`.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` without an ack, go to DONE with `fault`=1.
- DONE: `done`=1 for exactly this cycle.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
  - Loads drive the same enables.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extract: shift `mem_rdata` right by 8·addr[1:0]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW takes the whole word.
- `rdata` is unchanged by stores, faults and timeouts.
- `stall` = (state==REQ) | (start & (state==IDLE | state==DONE) & next state≠DONE-without-fault). Faulting starts still stall for one cycle; the rule is simply stall=1 whenever `start` is accepted or state is REQ.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset: state IDLE; `done`, `fault`, `mem_req`, `mem_we`=0; `mem_addr`, `mem_be`, `mem_wdata`, `rdata`=0; counter 0. Reset in REQ drops `mem_req` on the next edge, and a later `mem_ack` is ignored.
- Minimum latency: `start` in cycle 0, REQ with `mem_ack`=1 in cycle 1, `done` in cycle 2.
- Fault on decode: `done`=`fault`=1 in cycle 1, `mem_req` never asserted.
- Timeout: `mem_req` high for exactly `TIMEOUT` cycles, then DONE.
- Back-to-back: `start` during DONE is accepted; REQ follows with no idle cycle.
- Counter: $clog2(TIMEOUT+1) bits, cleared on REQ entry, saturating.

## Test plan
- LW addr=0x100, ack on the 1st REQ cycle, mem_rdata=0xDEADBEEF: mem_addr=0x100, mem_be=1111, done in cycle 2, rdata=0xDEADBEEF, fault=0.
- LB addr=0x103 and LBU addr=0x103, mem_rdata=0x80FF1234: LB gives rdata=0xFFFFFF80; LBU gives rdata=0x00000080; mem_be=1000.
- SH addr=0x22, wdata=0x0000ABCD, ack delayed 3 cycles: mem_addr=0x20, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, stall=1 for 4 cycles, rdata unchanged.
- LW addr=0x102, then SW mode 110: done=fault=1 in cycle 1 for each, mem_req never high.
- TIMEOUT=4 with no ack: mem_req high 4 cycles, then done=fault=1; a late mem_ack is ignored.
- rst asserted in the 2nd REQ cycle of a load: all outputs 0 next cycle, state IDLE; back-to-back SB then LW accepted in the DONE cycle with no idle gap.
